// File: rtl/itm_trace_decompression_if.sv
// Handshake bundle for the ITM trace decompressor: the compressed-message input
// side and the reconstructed per-instruction output side.
interface itm_trace_decompression_if #(
  parameter int TS_WIDTH          = 32,
  parameter int INSTR_COUNT_WIDTH = 8
);
  logic [TS_WIDTH+32+INSTR_COUNT_WIDTH-1:0] comp_in;
  logic                                     comp_in_valid;
  logic                                     comp_in_ready;
  logic [TS_WIDTH+32-1:0]                   trace_out;
  logic                                     trace_out_valid;
  logic                                     trace_out_ready;
  logic                                     busy;

  // master: message source and entry consumer
  modport master (
    output comp_in, comp_in_valid, trace_out_ready,
    input  comp_in_ready, trace_out, trace_out_valid, busy
  );

  // slave: the decompressor itself
  modport slave (
    input  comp_in, comp_in_valid, trace_out_ready,
    output comp_in_ready, trace_out, trace_out_valid, busy
  );
endinterface

// File: rtl/itm_trace_decompression.sv
// Expands compressed {ts, branch target, sequential count} messages into a
// per-instruction {ts, pc} stream with valid/ready flow control on both sides.
module itm_trace_decompression #(
  parameter int TS_WIDTH          = 32,
  parameter int INSTR_COUNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  itm_trace_decompression_if.slave      bus
);

  localparam int CW = INSTR_COUNT_WIDTH;
  localparam int MW = TS_WIDTH + 32 + CW;
  localparam int OW = TS_WIDTH + 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEQ    = 2'd1,
    BRANCH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           prev_pc_q, prev_pc_d;
  logic [31:0]           cur_pc_q, cur_pc_d;
  logic [CW-1:0]         remaining_q, remaining_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [31:0]           target_q, target_d;
  logic [OW-1:0]         trace_out_q, trace_out_d;
  logic                  trace_out_valid_q, trace_out_valid_d;

  logic [TS_WIDTH-1:0]   in_ts;
  logic [31:0]           in_pc;
  logic [CW-1:0]         in_cnt;
  logic                  comp_ready;
  logic                  accept;
  logic                  out_hs;
  logic                  load;
  logic [31:0]           load_base;

  assign in_ts  = bus.comp_in[MW-1 -: TS_WIDTH];
  assign in_pc  = bus.comp_in[CW +: 32];
  assign in_cnt = bus.comp_in[CW-1:0];

  // A new message may only enter while the final (branch) entry of the
  // current one is being handed off, so the stream never bubbles.
  assign comp_ready = (state_q == IDLE) ||
                      ((state_q == BRANCH) && bus.trace_out_ready);
  assign accept     = bus.comp_in_valid && comp_ready;
  assign out_hs     = trace_out_valid_q && bus.trace_out_ready;

  always_comb begin
    state_d     = state_q;
    prev_pc_d   = prev_pc_q;
    cur_pc_d    = cur_pc_q;
    remaining_d = remaining_q;
    ts_d        = ts_q;
    target_d    = target_q;
    load        = 1'b0;
    load_base   = prev_pc_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          load_base = prev_pc_q;
        end
      end
      SEQ: begin
        if (out_hs) begin
          cur_pc_d    = cur_pc_q + 32'd4;
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1)) begin
            state_d = BRANCH;
          end
        end
      end
      BRANCH: begin
        if (out_hs) begin
          prev_pc_d = target_q;
          if (accept) begin
            load      = 1'b1;
            load_base = target_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      ts_d        = in_ts;
      target_d    = in_pc;
      remaining_d = in_cnt;
      cur_pc_d    = load_base + 32'd4;
      state_d     = (in_cnt != '0) ? SEQ : BRANCH;
    end
  end

  // Output register is computed from next state so it always mirrors the
  // registered state with no path from comp_in to trace_out.
  always_comb begin
    trace_out_valid_d = (state_d != IDLE);
    case (state_d)
      SEQ:     trace_out_d = {ts_d, cur_pc_d};
      BRANCH:  trace_out_d = {ts_d, target_d};
      default: trace_out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      prev_pc_q         <= '0;
      cur_pc_q          <= '0;
      remaining_q       <= '0;
      ts_q              <= '0;
      target_q          <= '0;
      trace_out_q       <= '0;
      trace_out_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      prev_pc_q         <= prev_pc_d;
      cur_pc_q          <= cur_pc_d;
      remaining_q       <= remaining_d;
      ts_q              <= ts_d;
      target_q          <= target_d;
      trace_out_q       <= trace_out_d;
      trace_out_valid_q <= trace_out_valid_d;
    end
  end

  assign bus.comp_in_ready   = comp_ready;
  assign bus.trace_out       = trace_out_q;
  assign bus.trace_out_valid = trace_out_valid_q;
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_itm_trace_decompression.sv
// Bench for itm_trace_decompression: directed scenarios plus randomized traffic,
// checked against a message-level expansion model.
module tb_itm_trace_decompression;

  logic clk;
  logic rst_n;

  itm_trace_decompression_if #(.TS_WIDTH(32), .INSTR_COUNT_WIDTH(8)) bus ();

  itm_trace_decompression #(.TS_WIDTH(32), .INSTR_COUNT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_fail;
  int          cyc;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_cyc[$];
  logic [31:0] m_prev;
  bit          rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake just before the edge that completes it.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && bus.trace_out_valid && bus.trace_out_ready) begin
      obs_q.push_back(bus.trace_out);
      obs_cyc.push_back(cyc + 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Reference: a message expands to cnt entries stepping by 4 from the
  // previous target, followed by the new target.
  function automatic void model_add(input logic [31:0] ts, input logic [31:0] pc,
                                    input logic [7:0] cnt);
    for (int i = 1; i <= int'(cnt); i++)
      exp_q.push_back({ts, m_prev + 32'(4 * i)});
    exp_q.push_back({ts, pc});
    m_prev = pc;
  endfunction

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic send(input logic [31:0] ts, input logic [31:0] pc,
                      input logic [7:0] cnt, output int acc);
    @(negedge clk);
    bus.comp_in       = {ts, pc, cnt};
    bus.comp_in_valid = 1'b1;
    model_add(ts, pc, cnt);
    acc = -1;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (bus.comp_in_ready) begin
        acc = cyc + 1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL send_accept: got no accept want accept of pc %h", pc);
    end
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    @(negedge clk);
    bus.comp_in_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (obs_q.size() >= exp_q.size() && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.trace_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", bus.trace_out_valid);
    end
    n_cmp++;
    if (bus.trace_out !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", bus.trace_out);
    end
    n_cmp++;
    if (bus.comp_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", bus.comp_in_ready);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first();
    int acc;
    clear_q();
    send(32'h10, 32'h100, 8'd0, acc);
    drain(50);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL first_count: got %0d want 1", obs_q.size());
    end
    if (obs_q.size() >= 1) begin
      n_cmp++;
      if (obs_q[0] !== 64'h00000010_00000100) begin
        n_fail++; $display("FAIL first_entry: got %h want %h", obs_q[0], 64'h00000010_00000100);
      end
      n_cmp++;
      if (obs_cyc[0] != acc + 1) begin
        n_fail++; $display("FAIL first_latency: got cycle %0d want %0d", obs_cyc[0], acc + 1);
      end
    end
  endtask

  task automatic test_seq();
    int acc;
    clear_q();
    send(32'h20, 32'h2000, 8'd3, acc);
    drain(50);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL seq_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL seq_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      n_cmp++;
      if (obs_cyc[i] != acc + 1 + i) begin
        n_fail++; $display("FAIL seq_cycle%0d: got %0d want %0d", i, obs_cyc[i], acc + 1 + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    clear_q();
    send(32'h30, 32'h400, 8'd1, a1);
    send(32'h31, 32'h800, 8'd0, a2);
    drain(50);
    n_cmp++;
    if (a2 != a1 + 2) begin
      n_fail++; $display("FAIL b2b_accept: got cycle %0d want %0d", a2, a1 + 2);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      n_cmp++;
      if (obs_cyc[i] != a1 + 1 + i) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got %0d want %0d", i, obs_cyc[i], a1 + 1 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    int          acc;
    logic        pat[4];
    logic [63:0] held;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    held = '0;
    clear_q();
    send(32'h40, 32'h500, 8'd2, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.comp_in_valid   = 1'b0;
      bus.trace_out_ready = pat[i];
      #1;
      n_cmp++;
      if (bus.comp_in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready%0d: got %b want 0", i, bus.comp_in_ready);
      end
      if (i > 0 && !pat[i-1]) begin
        n_cmp++;
        if (bus.trace_out !== held) begin
          n_fail++; $display("FAIL bp_hold%0d: got %h want %h", i, bus.trace_out, held);
        end
      end
      held = bus.trace_out;
    end
    @(negedge clk);
    bus.trace_out_ready = 1'b1;
    drain(50);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int acc;
    clear_q();
    send(32'h50, 32'hFFFF_FFF8, 8'd0, acc);
    send(32'h51, 32'h0000_0040, 8'd2, acc);
    drain(50);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_max_count();
    int acc;
    clear_q();
    send(32'h60, 32'h0000_1234, 8'd255, acc);
    drain(400);
    n_cmp++;
    if (obs_q.size() != 256) begin
      n_fail++; $display("FAIL max_count: got %0d want 256", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL max_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_cyc.size() == 256) begin
      n_cmp++;
      if (obs_cyc[255] != acc + 256) begin
        n_fail++; $display("FAIL max_span: got cycle %0d want %0d", obs_cyc[255], acc + 256);
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    rnd_done = 1'b0;
    fork
      begin
        int acc;
        for (int m = 0; m < 20; m++) begin
          send($urandom, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 6)), acc);
          if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            bus.comp_in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          bus.trace_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.trace_out_ready = 1'b1;
    drain(3000);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_q();
    send(32'h70, 32'h900, 8'd10, acc);
    @(negedge clk);
    bus.comp_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.trace_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_valid: got %b want 0", bus.trace_out_valid);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_busy: got %b want 0", bus.busy);
    end
    clear_q();
    m_prev = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.comp_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_ready: got %b want 1", bus.comp_in_ready);
    end
    send(32'h71, 32'h8, 8'd1, acc);
    drain(50);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rmid_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rmid_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    n_cmp               = 0;
    n_fail              = 0;
    cyc                 = 0;
    m_prev              = 32'h0;
    rnd_done            = 1'b0;
    rst_n               = 1'b0;
    bus.comp_in         = '0;
    bus.comp_in_valid   = 1'b0;
    bus.trace_out_ready = 1'b1;

    test_reset();
    test_first();
    test_seq();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_max_count();
    test_random();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
